vend_dispense_ctrl: RTL

//   Downstream stage of the vending Mealy FSM. Consumes its one-cycle sell/change

---
 rtl/vend_dispense_ctrl.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl: queues sales from the vend FSM and sequences each one
// through product motor, drop-sensor check and change-coin ejection.
module vend_dispense_ctrl #(
    parameter int PEND_DEPTH = 4,
    parameter int MOTOR_CYC  = 8,
    parameter int DROP_TMO   = 32,
    parameter int EJECT_CYC  = 4,
    parameter int GAP_CYC    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sell,
    input  logic [1:0]                    change,
    input  logic                          drop_det,
    input  logic                          fault_clr,
    output logic                          motor_on,
    output logic                          eject_on,
    output logic                          busy,
    output logic                          vend_done,
    output logic                          ovf,
    output logic                          fault,
    output logic [$clog2(PEND_DEPTH):0]   pend_cnt
);

    localparam int AW    = $clog2(PEND_DEPTH);
    localparam int PW    = AW + 1;
    localparam int MAX_A = (MOTOR_CYC > DROP_TMO) ? MOTOR_CYC : DROP_TMO;
    localparam int MAX_B = (EJECT_CYC > GAP_CYC) ? EJECT_CYC : GAP_CYC;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_P) + 1;

    localparam logic [TW-1:0] MOTOR_LD = TW'(MOTOR_CYC - 1);
    localparam logic [TW-1:0] DROP_LD  = TW'(DROP_TMO - 1);
    localparam logic [TW-1:0] EJECT_LD = TW'(EJECT_CYC - 1);
    localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYC - 1);
    localparam logic [PW-1:0] FULL_CNT = PW'(PEND_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_MOTOR = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EJECT = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAULT = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [1:0]    chg_q, chg_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]    mem_q [PEND_DEPTH];

    logic motor_on_q, motor_on_d;
    logic eject_on_q, eject_on_d;
    logic busy_q, busy_d;
    logic vend_done_q, vend_done_d;
    logic ovf_q, ovf_d;
    logic fault_q, fault_d;

    logic pop, push, full;

    // A full queue still accepts a sell when the head leaves in the same cycle.
    always_comb begin
        pop      = (state_q == S_IDLE) && (cnt_q != '0);
        full     = (cnt_q == FULL_CNT);
        push     = sell && (!full || pop);
        ovf_d    = sell && full && !pop;
        cnt_d    = cnt_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push && !pop) begin
            cnt_d = cnt_q + PW'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        chg_d   = chg_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_MOTOR;
                    tmr_d   = MOTOR_LD;
                    chg_d   = mem_q[rd_ptr_q];
                end
            end
            S_MOTOR: begin
                if (tmr_q == '0) begin
                    state_d = S_WAIT;
                    tmr_d   = DROP_LD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_WAIT: begin
                if (drop_det) begin
                    state_d = (chg_q != 2'd0) ? S_EJECT : S_DONE;
                    tmr_d   = EJECT_LD;
                end else if (tmr_q == '0) begin
                    state_d = S_FAULT;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_EJECT: begin
                if (tmr_q == '0) begin
                    state_d = S_GAP;
                    tmr_d   = GAP_LD;
                    chg_d   = chg_q - 2'd1;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_GAP: begin
                if (tmr_q == '0) begin
                    state_d = (chg_q != 2'd0) ? S_EJECT : S_DONE;
                    tmr_d   = EJECT_LD;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they track state_q exactly.
    always_comb begin
        motor_on_d  = (state_d == S_MOTOR);
        eject_on_d  = (state_d == S_EJECT);
        vend_done_d = (state_d == S_DONE);
        fault_d     = (state_d == S_FAULT);
        busy_d      = (state_d != S_IDLE) || (cnt_d != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            chg_q       <= '0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            motor_on_q  <= 1'b0;
            eject_on_q  <= 1'b0;
            busy_q      <= 1'b0;
            vend_done_q <= 1'b0;
            ovf_q       <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            chg_q       <= chg_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            motor_on_q  <= motor_on_d;
            eject_on_q  <= eject_on_d;
            busy_q      <= busy_d;
            vend_done_q <= vend_done_d;
            ovf_q       <= ovf_d;
            fault_q     <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= change;
        end
    end

    assign motor_on  = motor_on_q;
    assign eject_on  = eject_on_q;
    assign busy      = busy_q;
    assign vend_done = vend_done_q;
    assign ovf       = ovf_q;
    assign fault     = fault_q;
    assign pend_cnt  = cnt_q;

endmodule
